// File: rtl/shift_add_sequential_multiplier_if.sv
// Operand/result bundle for the 32x32 shift-and-add / Booth multiplier.
interface shift_add_sequential_multiplier_if;
  logic               load;
  logic               sign_multiplicand;
  logic               sign_multiplier;
  logic        [31:0] multiplicand;
  logic        [31:0] multiplier;
  logic signed [31:0] signed_multiplicand;
  logic signed [31:0] signed_multiplier;
  logic        [31:0] result;
  logic signed [31:0] signed_result;
  logic               done;

  modport master (
    output load, sign_multiplicand, sign_multiplier,
    output multiplicand, multiplier, signed_multiplicand, signed_multiplier,
    input  result, signed_result, done
  );

  modport slave (
    input  load, sign_multiplicand, sign_multiplier,
    input  multiplicand, multiplier, signed_multiplicand, signed_multiplier,
    output result, signed_result, done
  );
endinterface

// File: rtl/shift_add_sequential_multiplier.sv
// Radix-2 sequential multiplier: unsigned shift-and-add with an optional parallel
// signed Booth path. 32 iterations per operation; results are the low 32 product bits.
module shift_add_sequential_multiplier #(
  parameter bit sign_op = 1'b1
) (
  input logic                               clk,
  input logic                               rst,
  shift_add_sequential_multiplier_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_iter, w_finish;
  logic [5:0]  r_count;

  logic [63:0] partial_product;
  logic [31:0] multiplier_reg;
  logic [31:0] r_multiplicand;
  logic [32:0] w_sum;

  logic [32:0] signed_partial_product;
  logic [32:0] multiplier_booth_recoded;
  logic [32:0] r_signed_multiplicand;
  logic        r_q_m1;
  logic [32:0] w_bacc;

  logic [31:0] r_result;
  logic [31:0] r_signed_result;
  logic        r_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_iter      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.load) w_state_nxt = S_BUSY;
      S_BUSY: begin
        w_iter = ~bus.load;
        if (bus.load)          w_state_nxt = S_BUSY;
        else if (r_count == 6'd1) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_finish    = 1'b1;
        w_state_nxt = bus.load ? S_BUSY : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Carry-out of the upper-half add is shifted back in at the top.
  always_comb begin
    w_sum = {1'b0, partial_product[63:32]};
    if (multiplier_reg[0]) w_sum = w_sum + {1'b0, r_multiplicand};
  end

  always_comb begin
    w_bacc = signed_partial_product;
    case ({multiplier_booth_recoded[0], r_q_m1})
      2'b01:   w_bacc = signed_partial_product + r_signed_multiplicand;
      2'b10:   w_bacc = signed_partial_product - r_signed_multiplicand;
      default: w_bacc = signed_partial_product;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count         <= '0;
      partial_product <= '0;
      multiplier_reg  <= '0;
      r_multiplicand  <= '0;
    end else if (bus.load) begin
      r_count         <= 6'd32;
      partial_product <= '0;
      multiplier_reg  <= bus.multiplier;
      r_multiplicand  <= bus.multiplicand;
    end else if (w_iter) begin
      r_count         <= r_count - 6'd1;
      partial_product <= {w_sum, partial_product[31:1]};
      multiplier_reg  <= {partial_product[0], multiplier_reg[31:1]};
    end
  end

  // Signed path stays cleared when sign_op is off.
  always_ff @(posedge clk) begin
    if (rst || !sign_op) begin
      signed_partial_product   <= '0;
      multiplier_booth_recoded <= '0;
      r_signed_multiplicand    <= '0;
      r_q_m1                   <= 1'b0;
    end else if (bus.load) begin
      signed_partial_product   <= '0;
      multiplier_booth_recoded <= {bus.sign_multiplier & bus.signed_multiplier[31],
                                   bus.signed_multiplier};
      r_signed_multiplicand    <= {bus.sign_multiplicand & bus.signed_multiplicand[31],
                                   bus.signed_multiplicand};
      r_q_m1                   <= 1'b0;
    end else if (w_iter) begin
      signed_partial_product   <= {w_bacc[32], w_bacc[32:1]};
      multiplier_booth_recoded <= {w_bacc[0], multiplier_booth_recoded[32:1]};
      r_q_m1                   <= multiplier_booth_recoded[0];
    end
  end

  // After 32 shifts the low product bits sit in Q[32:1]; Q[0] is the unused sign bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result        <= '0;
      r_signed_result <= '0;
      r_done          <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_result        <= partial_product[31:0];
        r_signed_result <= sign_op ? multiplier_booth_recoded[32:1] : 32'd0;
      end
    end
  end

  assign bus.result        = r_result;
  assign bus.signed_result = r_signed_result;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_shift_add_sequential_multiplier.sv
// Directed bench: one instance with the signed path enabled, one with it disabled.
module tb_shift_add_sequential_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        fa = 1'b0, fb = 1'b0;
  logic [31:0] a = '0, b = '0, sa = '0, sb = '0;
  int          n_chk = 0;
  int          n_err = 0;
  int          p;

  always #5 clk = ~clk;

  shift_add_sequential_multiplier_if bus1 ();
  shift_add_sequential_multiplier_if bus0 ();

  assign bus1.load = load;  assign bus0.load = load;
  assign bus1.sign_multiplicand = fa;  assign bus0.sign_multiplicand = fa;
  assign bus1.sign_multiplier   = fb;  assign bus0.sign_multiplier   = fb;
  assign bus1.multiplicand = a;  assign bus0.multiplicand = a;
  assign bus1.multiplier   = b;  assign bus0.multiplier   = b;
  assign bus1.signed_multiplicand = sa;  assign bus0.signed_multiplicand = sa;
  assign bus1.signed_multiplier   = sb;  assign bus0.signed_multiplier   = sb;

  shift_add_sequential_multiplier #(.sign_op(1'b1)) u_dut  (.clk(clk), .rst(rst), .bus(bus1));
  shift_add_sequential_multiplier #(.sign_op(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      tick;
      if (bus1.done) pulses++;
      if (bus0.done) pulses++;
    end
  endtask

  task automatic drive(input logic [31:0] ia, ib, isa, isb, input logic ifa, ifb);
    a = ia; b = ib; sa = isa; sb = isb; fa = ifa; fb = ifb;
    load = 1'b1;
  endtask

  // Operands are scrambled after the load edge to show they are not re-sampled.
  task automatic start(input logic [31:0] ia, ib, isa, isb, input logic ifa, ifb);
    drive(ia, ib, isa, isb, ifa, ifb);
    tick;
    load = 1'b0;
    a = $urandom; b = $urandom; sa = $urandom; sb = $urandom;
    fa = 1'($urandom); fb = 1'($urandom);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] eu, es);
    int q;
    run(32, q);
    check({tag, "/early_done"}, q, 0);
    tick;
    check({tag, "/done"},      {31'd0, bus1.done}, 1);
    check({tag, "/result"},    bus1.result, eu);
    check({tag, "/sresult"},   bus1.signed_result, es);
    check({tag, "/done0"},     {31'd0, bus0.done}, 1);
    check({tag, "/result0"},   bus0.result, eu);
    check({tag, "/sresult0"},  bus0.signed_result, 0);
    tick;
    check({tag, "/done_pulse"}, {31'd0, bus1.done}, 0);
    check({tag, "/hold"},       bus1.result, eu);
  endtask

  initial begin
    rst = 1'b1;
    tick; tick;
    check("reset/result",  bus1.result, 0);
    check("reset/sresult", bus1.signed_result, 0);
    check("reset/done",    {31'd0, bus1.done}, 0);
    check("reset/pp_lo",   u_dut.partial_product[31:0], 0);
    check("reset/spp",     u_dut.signed_partial_product[31:0], 0);
    rst = 1'b0;
    tick;

    // 5678982 * 2502684 = 14212697387688 = {3309, 650605224}
    start(32'd5678982, 32'd2502684, 32'd24, -32'sd24, 1'b0, 1'b1);
    finish_op("basic", 32'd650605224, 32'hFFFFFDC0);
    check("basic/pp_hi", u_dut.partial_product[63:32], 32'd3309);
    check("basic/pp_lo", u_dut.partial_product[31:0], 32'd650605224);

    start(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    finish_op("minint", 32'h00000001, 32'h80000000);

    start(32'h00010001, 32'h00010001, -32'sd7, -32'sd9, 1'b1, 1'b1);
    finish_op("negneg", 32'h00020001, 32'd63);

    start(32'd0, 32'd123, 32'd0, -32'sd12345, 1'b1, 1'b1);
    finish_op("zero", 32'd0, 32'd0);

    // Restart: second load ten cycles in; the first operation never reports.
    start(32'd1000, 32'd1000, 32'd1000, 32'd1000, 1'b0, 1'b0);
    run(9, p);
    check("restart/pre", p, 0);
    start(32'd3, 32'd5, 32'd3, 32'd5, 1'b1, 1'b1);
    finish_op("restart", 32'd15, 32'd15);

    // Load on the DONE edge: old result reported, new operation starts.
    start(32'd7, 32'd6, 32'd7, 32'd6, 1'b1, 1'b1);
    run(32, p);
    check("b2b/pre", p, 0);
    drive(32'd9, 32'd9, 32'd9, -32'sd9, 1'b1, 1'b1);
    tick;
    load = 1'b0;
    check("b2b/done",    {31'd0, bus1.done}, 1);
    check("b2b/result",  bus1.result, 32'd42);
    check("b2b/sresult", bus1.signed_result, 32'd42);
    finish_op("b2b2", 32'd81, 32'hFFFFFFAF);

    // Reset mid-operation.
    start(32'd100, 32'd100, 32'd100, 32'd100, 1'b1, 1'b1);
    run(19, p);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rstmid/result",  bus1.result, 0);
    check("rstmid/sresult", bus1.signed_result, 0);
    check("rstmid/done",    {31'd0, bus1.done}, 0);
    run(20, p);
    check("rstmid/no_done", p, 0);
    start(32'd11, 32'd13, -32'sd11, 32'd13, 1'b1, 1'b1);
    finish_op("after_rst", 32'd143, 32'hFFFFFF71);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
